// File: rtl/q2_pkg.sv
// Shared constants and helpers for the q2 memory/IO responder.
// Holds the bus word width, the memory-mapped IO addresses at the top of
// the address space, the status-word bit layout and small decode helpers.
package q2_pkg;

    localparam int WORD_W = 12;

    // Memory-mapped IO words
    localparam logic [WORD_W-1:0] ADDR_OUT  = 12'hFFF;  // console output stream
    localparam logic [WORD_W-1:0] ADDR_IN   = 12'hFFE;  // console input
    localparam logic [WORD_W-1:0] ADDR_STAT = 12'hFFD;  // IO status

    // Status word bit positions
    localparam int STAT_FULL  = 0;  // output path cannot accept a push
    localparam int STAT_EMPTY = 1;  // no unconsumed output word
    localparam int STAT_OVF   = 2;  // sticky: an output word was dropped

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_IN   = 2'd1,
        SEL_STAT = 2'd2
    } addr_sel_e;

    // Select the read source for an address. 0xFFF reads back the RAM copy,
    // so it decodes as ordinary RAM.
    function automatic addr_sel_e addr_decode(input logic [WORD_W-1:0] addr);
        addr_sel_e sel;
        case (addr)
            ADDR_IN:   sel = SEL_IN;
            ADDR_STAT: sel = SEL_STAT;
            default:   sel = SEL_RAM;
        endcase
        return sel;
    endfunction

    // Console input word: valid flag above the byte, byte masked when idle.
    function automatic logic [WORD_W-1:0] in_word(input logic valid, input logic [7:0] data);
        return {3'b000, valid, (valid ? data : 8'h00)};
    endfunction

    // IO status word assembled from the output-path flags.
    function automatic logic [WORD_W-1:0] stat_word(input logic ovf,
                                                    input logic valid,
                                                    input logic full);
        logic [WORD_W-1:0] w;
        w             = '0;
        w[STAT_OVF]   = ovf;
        w[STAT_EMPTY] = ~valid;
        w[STAT_FULL]  = full;
        return w;
    endfunction

endpackage

// File: rtl/q2_out_fifo.sv
// Console output FIFO for q2_mem_io.
// Push is dropped (and the sticky ovf flag set) only when the FIFO is full
// and no pop happens in the same cycle; a same-cycle pop frees the slot.
// Head word is presented combinationally and stays stable until popped.
module q2_out_fifo
    import q2_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             ovf_reg;

    logic do_pop;
    logic do_push;
    logic drop;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign data    = mem_reg[rd_ptr_reg];
    assign ovf     = ovf_reg;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow; pointers wrap by width
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/q2_mem_io.sv
// Memory/IO responder for the q2 CPU bus (abus/dbus/rdm/wrm target side).
// Word RAM plus console output (0xFFF), console input (0xFFE) and IO
// status (0xFFD). Reads are combinational; writes happen once per rising
// edge of wrm. Build option Q2_MEM_OUTFIFO_EN selects a FIFO_DEPTH-entry
// output FIFO; without it the output path is a single holding register.
module q2_mem_io
    import q2_pkg::*;
#(
    parameter int AW = 12      // RAM address width, at most WORD_W
`ifdef Q2_MEM_OUTFIFO_EN
    ,
    parameter int FIFO_DEPTH = 4  // power of two, >= 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] abus,
    inout  wire  [WORD_W-1:0] dbus,
    input  logic              rdm,
    input  logic              wrm,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready
);

    logic [WORD_W-1:0] ram_mem [1 << AW];

    logic              rdm_q_reg;
    logic              wrm_q_reg;
    logic              in_ready_reg;

    logic              rd_edge;
    logic              wr_edge;
    logic              wr_take;
    logic              in_range;
    logic [AW-1:0]     ram_addr;
    addr_sel_e         addr_sel;
    logic [WORD_W-1:0] rdata;

    logic              out_push;
    logic              out_pop;
    logic              ovf_clr;
    logic              out_full;
    logic              ovf_flag;
    logic              out_valid_int;
    logic [WORD_W-1:0] out_data_int;

    assign ram_addr = abus[AW-1:0];
    assign addr_sel = addr_decode(abus);

    // Addresses beyond the RAM read as zero and are never written
    generate
        if (AW >= WORD_W) begin : g_full_map
            assign in_range = 1'b1;
        end else begin : g_part_map
            assign in_range = ((abus >> AW) == '0);
        end
    endgenerate

    assign rd_edge = rdm & ~rdm_q_reg;
    assign wr_edge = wrm & ~wrm_q_reg;
    // Writes are suppressed during reset so a strobe overlapping reset is harmless
    assign wr_take = wr_edge & ~rst;

    assign out_push = wr_take & (abus == ADDR_OUT);
    assign ovf_clr  = wr_take & (abus == ADDR_STAT) & dbus[STAT_OVF];
    assign out_pop  = out_valid_int & out_ready;

    // Strobe history and the one-cycle input-consume pulse. Both strobe
    // registers reset high so a strobe held across reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdm_q_reg    <= 1'b1;
            wrm_q_reg    <= 1'b1;
            in_ready_reg <= 1'b0;
        end else begin
            rdm_q_reg    <= rdm;
            wrm_q_reg    <= wrm;
            in_ready_reg <= rd_edge & (abus == ADDR_IN) & in_valid;
        end
    end

    // RAM write on the wrm rising edge; IO addresses keep a RAM copy too
    always_ff @(posedge clk) begin
        if (wr_take && in_range) begin
            ram_mem[ram_addr] <= dbus;
        end
    end

    // Read data mux
    always_comb begin
        rdata = '0;
        case (addr_sel)
            SEL_IN:   rdata = in_word(in_valid, in_data);
            SEL_STAT: rdata = stat_word(ovf_flag, out_valid_int, out_full);
            default: begin
                if (in_range) begin
                    rdata = ram_mem[ram_addr];
                end
            end
        endcase
    end

    // Drive the shared bus only for a clean read; rdm & wrm together is a
    // protocol error and leaves the bus released.
    assign dbus = (rdm & ~wrm) ? rdata : 'z;

`ifdef Q2_MEM_OUTFIFO_EN
    q2_out_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_push),
        .push_data (dbus),
        .full      (out_full),
        .pop       (out_pop),
        .valid     (out_valid_int),
        .data      (out_data_int),
        .ovf       (ovf_flag),
        .ovf_clr   (ovf_clr)
    );
`else
    logic [WORD_W-1:0] hold_data_reg;
    logic              hold_valid_reg;
    logic              ovf_reg;
    logic              hold_accept;

    // A push lands if the register is empty or is being drained this cycle
    assign hold_accept = out_push & (~hold_valid_reg | out_pop);

    // Holding register data
    always_ff @(posedge clk) begin
        if (hold_accept) begin
            hold_data_reg <= dbus;
        end
    end

    // Holding register occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            if (hold_accept) begin
                hold_valid_reg <= 1'b1;
            end else if (out_pop) begin
                hold_valid_reg <= 1'b0;
            end
            if (out_push && !hold_accept) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign out_full      = hold_valid_reg;
    assign out_valid_int = hold_valid_reg;
    assign out_data_int  = hold_data_reg;
    assign ovf_flag      = ovf_reg;
`endif

    assign out_data  = out_data_int;
    assign out_valid = out_valid_int;
    assign in_ready  = in_ready_reg;

endmodule
